// File: rtl/reg_bank_sequencer.sv
// -----------------------------------------------------------------------------
// reg_bank_sequencer
//
// Initiator side of a 32-bit chip-select register bank. Operand fetches are
// turned into one-hot read selects on ports A/B. The tri-stated DoA/DoB buses
// are captured on the falling edge inside the READ cycle, and the operands are
// then presented over a valid/ready handshake. Write-backs from the datapath
// are issued as a one-cycle CSc/WEc/DinC pulse. A pending write-back always
// wins over a fetch, so a fetch accepted after a write-back sees the new data.
//
// Optional build macro:
//   REG0_ZERO_EN - register 0 is hardwired to zero. Reads of address 0 select
//                  nothing and return 0. Writes to address 0 complete the
//                  handshake but drive neither CSc nor WEc.
//
// Parameters:
//   NREG - number of register cells (width of each select bus)
//   AW   - register address width (2**AW >= NREG)
//   DW   - data width
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - operand fetch handshake, sources req_ra/req_rb
//   op_valid/op_ready   - operand delivery handshake, data op_a/op_b
//   wb_valid/wb_ready   - write-back handshake, wb_addr/wb_data
//   CSa/CSb             - one-hot read selects (registered)
//   CSc/WEc/DinC        - one-hot write select, write enable, write data
//   DoA/DoB             - shared read buses, valid while clk is low
// -----------------------------------------------------------------------------
module reg_bank_sequencer #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_ra,
  input  logic [AW-1:0]   req_rb,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [DW-1:0]   op_a,
  output logic [DW-1:0]   op_b,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  output logic [NREG-1:0] CSa,
  output logic [NREG-1:0] CSb,
  output logic [NREG-1:0] CSc,
  output logic            WEc,
  output logic [DW-1:0]   DinC,
  input  logic [DW-1:0]   DoA,
  input  logic [DW-1:0]   DoB
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    HOLD
  } state_e;

  // True when the address names a real, non-hardwired cell.
  function automatic logic addr_live(input logic [AW-1:0] addr);
`ifdef REG0_ZERO_EN
    return (int'(addr) < NREG) && (addr != '0);
`else
    return int'(addr) < NREG;
`endif
  endfunction

  // One-hot select, all-zero for out-of-range or hardwired addresses.
  function automatic logic [NREG-1:0] sel_of(input logic [AW-1:0] addr);
    logic [NREG-1:0] sel;
    sel = '0;
    if (addr_live(addr)) sel[addr] = 1'b1;
    return sel;
  endfunction

  // Out-of-range writes still pulse WEc; only the hardwired zero register
  // suppresses the pulse.
  function automatic logic we_of(input logic [AW-1:0] addr);
`ifdef REG0_ZERO_EN
    return addr != '0;
`else
    return 1'b1;
`endif
  endfunction

  state_e          state_q, state_d;
  logic [NREG-1:0] cs_a_q, cs_a_d;
  logic [NREG-1:0] cs_b_q, cs_b_d;
  logic [NREG-1:0] cs_c_q, cs_c_d;
  logic            we_c_q, we_c_d;
  logic [DW-1:0]   din_c_q, din_c_d;
  // Whether each read port has a cell driving it; otherwise the bus floats.
  logic            rd_a_ok_q, rd_a_ok_d;
  logic            rd_b_ok_q, rd_b_ok_d;
  logic [DW-1:0]   op_a_q, op_a_d;
  logic [DW-1:0]   op_b_q, op_b_d;
  // Falling-edge capture of the read buses.
  logic [DW-1:0]   cap_a_q, cap_b_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves a variable unassigned (which would infer a latch).
    state_d   = state_q;
    cs_a_d    = '0;
    cs_b_d    = '0;
    cs_c_d    = '0;
    we_c_d    = 1'b0;
    din_c_d   = din_c_q;
    rd_a_ok_d = rd_a_ok_q;
    rd_b_ok_d = rd_b_ok_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;

    unique case (state_q)
      IDLE: begin
        if (wb_valid) begin
          state_d = WRITE;
          cs_c_d  = sel_of(wb_addr);
          we_c_d  = we_of(wb_addr);
          din_c_d = wb_data;
        end else if (req_valid) begin
          state_d   = READ;
          cs_a_d    = sel_of(req_ra);
          cs_b_d    = sel_of(req_rb);
          rd_a_ok_d = addr_live(req_ra);
          rd_b_ok_d = addr_live(req_rb);
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        // Operands move from the mid-cycle capture to the outputs as
        // op_valid rises, so a reset can clear them at a rising edge.
        state_d = HOLD;
        op_a_d  = cap_a_q;
        op_b_d  = cap_b_q;
      end
      HOLD: if (op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      cs_a_q    <= '0;
      cs_b_q    <= '0;
      cs_c_q    <= '0;
      we_c_q    <= 1'b0;
      din_c_q   <= '0;
      rd_a_ok_q <= 1'b0;
      rd_b_ok_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      cs_a_q    <= cs_a_d;
      cs_b_q    <= cs_b_d;
      cs_c_q    <= cs_c_d;
      we_c_q    <= we_c_d;
      din_c_q   <= din_c_d;
      rd_a_ok_q <= rd_a_ok_d;
      rd_b_ok_q <= rd_b_ok_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  // NOTE: the capture registers are pure datapath and carry no reset. They are
  // only consumed on leaving READ, and by then they have always been written.
  // An unselected port is forced to zero instead of sampling a floating bus.
  always_ff @(negedge clk) begin
    if (state_q == READ) begin
      cap_a_q <= rd_a_ok_q ? DoA : '0;
      cap_b_q <= rd_b_ok_q ? DoB : '0;
    end
  end

  assign wb_ready  = (state_q == IDLE);
  assign req_ready = (state_q == IDLE) && !wb_valid;
  assign op_valid  = (state_q == HOLD);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign CSa       = cs_a_q;
  assign CSb       = cs_b_q;
  assign CSc       = cs_c_q;
  assign WEc       = we_c_q;
  assign DinC      = din_c_q;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_sequencer
//
// Drives reg_bank_sequencer (NREG=12 so out-of-range addresses are reachable)
// against a behavioural register-bank model. Expected results come from a
// plain array holding the architectural register contents. Inputs are driven
// on the falling edge. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_bank_sequencer;

  localparam int NREG = 12;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready;
  logic [AW-1:0]   req_ra, req_rb;
  logic            op_valid, op_ready;
  logic [DW-1:0]   op_a, op_b;
  logic            wb_valid, wb_ready;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic [NREG-1:0] CSa, CSb, CSc;
  logic            WEc;
  logic [DW-1:0]   DinC;
  logic [DW-1:0]   DoA, DoB;

  int n_checks = 0;
  int n_errors = 0;

  reg_bank_sequencer #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ra(req_ra), .req_rb(req_rb),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .CSa(CSa), .CSb(CSb), .CSc(CSc), .WEc(WEc), .DinC(DinC),
    .DoA(DoA), .DoB(DoB)
  );

  always #5 clk = ~clk;

  // Register cells: each writes DinC when its CSc bit and WEc are high at a
  // rising edge. A read port with no selected cell shows a junk pattern,
  // standing in for a floating bus.
  logic [DW-1:0] cells [NREG];

  always @(posedge clk) begin
    if (WEc)
      for (int i = 0; i < NREG; i++)
        if (CSc[i]) cells[i] <= DinC;
  end

  always_comb begin
    DoA = 32'hA5A5_A5A5;
    DoB = 32'h5A5A_5A5A;
    for (int i = 0; i < NREG; i++) begin
      if (CSa[i]) DoA = cells[i];
      if (CSb[i]) DoB = cells[i];
    end
  end

  // Architectural view of the register file.
  logic [DW-1:0] ref_regs [16];

  function automatic bit live(input int a);
    if (a >= NREG) return 1'b0;
`ifdef REG0_ZERO_EN
    if (a == 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_sel(input int a);
    logic [31:0] one;
    one = 32'd1;
    return live(a) ? (one << a) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_we(input int a);
`ifdef REG0_ZERO_EN
    if (a == 0) return 32'd0;
`endif
    return 32'd1;
  endfunction

  function automatic logic [31:0] exp_val(input int a);
    return live(a) ? ref_regs[a] : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_addr  = AW'(a);
    wb_data  = d;
    #1;
    check("wb_ready idle", 32'(wb_ready), 32'd1);
    check("req_ready blocked by wb", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("CSc write", 32'(CSc), exp_sel(a));
    check("WEc write", 32'(WEc), exp_we(a));
    check("DinC write", DinC, d);
    check("CSa during write", 32'(CSa | CSb), 32'd0);
    if (live(a)) ref_regs[a] = d;
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    check("wb_ready in WRITE", 32'(wb_ready), 32'd0);
    @(posedge clk); #1;
    check("CSc after write", 32'(CSc), 32'd0);
    check("WEc after write", 32'(WEc), 32'd0);
  endtask

  task automatic do_read(input int ra, input int rb, input int nhold);
    logic [31:0] ea, eb;
    @(negedge clk);
    req_valid = 1'b1;
    req_ra    = AW'(ra);
    req_rb    = AW'(rb);
    #1;
    check("req_ready idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("CSa read", 32'(CSa), exp_sel(ra));
    check("CSb read", 32'(CSb), exp_sel(rb));
    check("CSc during read", 32'(CSc), 32'd0);
    check("op_valid T+1", 32'(op_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    ea = exp_val(ra);
    eb = exp_val(rb);
    check("op_valid T+2", 32'(op_valid), 32'd1);
    check("op_a", op_a, ea);
    check("op_b", op_b, eb);
    check("CSa/CSb in HOLD", 32'(CSa | CSb), 32'd0);
    for (int h = 0; h < nhold; h++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_ra    = AW'($urandom_range(0, 15));
      #1;
      check("req_ready in HOLD", 32'(req_ready), 32'd0);
      check("wb_ready in HOLD", 32'(wb_ready), 32'd0);
      @(posedge clk); #1;
      check("op_valid held", 32'(op_valid), 32'd1);
      check("op_a held", op_a, ea);
      check("op_b held", op_b, eb);
      check("selects idle in HOLD", 32'(CSa | CSb | CSc), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    op_ready  = 1'b1;
    @(posedge clk); #1;
    check("op_valid after take", 32'(op_valid), 32'd0);
    op_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_ra = '0; req_rb = '0;
    op_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset CSa", 32'(CSa), 32'd0);
    check("reset CSb", 32'(CSb), 32'd0);
    check("reset CSc", 32'(CSc), 32'd0);
    check("reset WEc", 32'(WEc), 32'd0);
    check("reset DinC", DinC, 32'd0);
    check("reset op_valid", 32'(op_valid), 32'd0);
    check("reset op_a", op_a, 32'd0);
    check("reset op_b", op_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Populate every address, including out-of-range ones.
    for (int i = 0; i < 16; i++) do_write(i, $urandom);

    // Write then read back on both ports.
    do_write(3, 32'hDEAD_BEEF);
    do_read(3, 3, 0);

    // Write-back wins a same-cycle collision; the fetch follows and sees it.
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'h1234_5678;
    req_valid = 1'b1; req_ra = 4'd5; req_rb = 4'd0;
    #1;
    check("collision wb_ready", 32'(wb_ready), 32'd1);
    check("collision req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("collision CSc", 32'(CSc), exp_sel(5));
    check("collision CSa", 32'(CSa), 32'd0);
    ref_regs[5] = 32'h1234_5678;
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    check("req_ready in WRITE", 32'(req_ready), 32'd0);
    do_read(5, 0, 0);

    // Ten cycles of backpressure.
    do_read(7, 9, 10);

    // Out-of-range addresses.
    do_read(14, 2, 1);
    do_write(13, 32'hCAFE_F00D);
    do_read(2, 15, 0);

    // Register 0 write and read (hardwired zero when the feature is built in).
    do_write(0, 32'hFFFF_FFFF);
    do_read(0, 1, 0);

    // Reset while in READ.
    do_read(3, 5, 0);
    @(negedge clk);
    req_valid = 1'b1; req_ra = 4'd7; req_rb = 4'd8;
    @(posedge clk); #1;
    check("CSa entering READ", 32'(CSa), exp_sel(7));
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst CSa", 32'(CSa), 32'd0);
    check("rst CSb", 32'(CSb), 32'd0);
    check("rst CSc/WEc", 32'(CSc) | 32'(WEc), 32'd0);
    check("rst op_valid", 32'(op_valid), 32'd0);
    check("rst op_a", op_a, 32'd0);
    check("rst op_b", op_b, 32'd0);
    check("rst wb_ready", 32'(wb_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_read(7, 8, 0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write($urandom_range(0, 15), $urandom);
      else
        do_read($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
